// File: rtl/pll_reset_seq.sv
// Reset/lock sequencer for the reference-clocked PLL wrapper.
// Pulses the PLL reset, waits for a synchronised lock that stays up for
// LOCK_STABLE cycles, then releases the system reset. Lock loss, lock
// timeout or soft_reset send the sequencer back to re-pulse the PLL.
// dbg_state exposes the FSM state (0 reset, 1 wait-lock, 2 stable, 3 run).
module pll_reset_seq #(
  parameter int SYNC_STAGES  = 2,
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 50000
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       soft_reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       ready,
  output logic       sys_rst,
  output logic [7:0] relock_count,
  output logic       timeout_err,
  output logic [1:0] dbg_state
);

  localparam int MAX_AB = (RST_CYCLES > LOCK_STABLE) ? RST_CYCLES : LOCK_STABLE;
  localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);

  localparam logic [1:0] S_RESET     = 2'd0;
  localparam logic [1:0] S_WAIT_LOCK = 2'd1;
  localparam logic [1:0] S_STABLE    = 2'd2;
  localparam logic [1:0] S_RUN       = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             relock_q, relock_d;
  logic                   tout_q, tout_d;
  logic                   pll_rst_q, ready_q, sys_rst_q;

  assign lk_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous PLL lock into the refclk domain.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  // Next-state logic; soft_reset is checked first in every state so it
  // wins over lock loss and over timeout on the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    relock_d = relock_q;
    tout_d   = tout_q;
    case (state_q)
      S_RESET: begin
        if (soft_reset)             cnt_d   = '0;
        else if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (soft_reset)                 state_d = S_RESET;
        else if (lk_s)                  state_d = S_STABLE;
        else if (cnt_q == TIMEOUT_LAST) begin
          state_d = S_RESET;
          tout_d  = 1'b1;
        end
      end
      S_STABLE: begin
        if (soft_reset)                state_d = S_RESET;
        else if (!lk_s)                state_d = S_WAIT_LOCK;
        else if (cnt_q == STABLE_LAST) state_d = S_RUN;
      end
      default: begin
        cnt_d = '0;
        if (soft_reset) state_d = S_RESET;
        else if (!lk_s) begin
          state_d = S_RESET;
          if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
        end
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter, statistics and registered outputs decoded from next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      relock_q  <= 8'd0;
      tout_q    <= 1'b0;
      pll_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      sys_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      relock_q  <= relock_d;
      tout_q    <= tout_d;
      pll_rst_q <= (state_d == S_RESET);
      ready_q   <= (state_d == S_RUN);
      sys_rst_q <= (state_d != S_RUN);
    end
  end

  assign pll_rst      = pll_rst_q;
  assign ready        = ready_q;
  assign sys_rst      = sys_rst_q;
  assign relock_count = relock_q;
  assign timeout_err  = tout_q;
  assign dbg_state    = state_q;

endmodule
